// File: rtl/fill_pkg.sv
// Shared types and sizing helpers for the icache/data line-fill arbiter.
package fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        COLLECT,
        IBURST,
        DRESP,
        HOLD
    } state_e;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    localparam int LINE_LENGTH_DEF = 4;
    localparam int LINE_NIBBLES    = LINE_LENGTH_DEF * 2;
    localparam int M_CNT_W         = 5;

    function automatic int line_nibbles(input int line_length);
        return line_length * 2;
    endfunction

    // Index width for a buffer of n nibbles, never narrower than one bit.
    function automatic int nib_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fill_rr_pick.sv
// Two-way requester pick: icache vs data. FILL_RR_EN selects round-robin with a
// last-grant pointer; otherwise fixed priority (icache first) with no state.
module fill_rr_pick (
`ifdef FILL_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic take,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic pick
);

`ifdef FILL_RR_EN
    import fill_pkg::*;

    // ptr names the requester favoured on the next tie.
    owner_e ptr;

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= OWN_I;
        else if (take)
            ptr <= pick ? OWN_I : OWN_D;
    end

    assign pick = d_req && (!i_req || ptr == OWN_D);
`else
    assign pick = d_req && !i_req;
`endif

endmodule

// File: rtl/fill_arb.sv
// Line-fill arbiter: fetches an icache line or a data word from nibble-serial
// memory, then bursts it to the icache or acks the data port. Macro: FILL_RR_EN.
module fill_arb
    import fill_pkg::*;
#(
    parameter int LINE_LENGTH = 4,
    parameter int PA          = 22,
    parameter int RV          = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_pull,
    input  logic [PA-$clog2(LINE_LENGTH)-1:0]    i_tag,
    output logic                                 i_wstrobe,
    output logic [3:0]                           i_dread,
    output logic                                 i_fault,
    input  logic                                 d_req,
    input  logic [PA-1:0]                        d_addr,
    output logic                                 d_ack,
    output logic                                 d_fault,
    output logic [RV-1:0]                        d_rdata,
    output logic                                 m_req,
    output logic [PA-1:0]                        m_addr,
    output logic [M_CNT_W-1:0]                   m_cnt,
    input  logic                                 m_gnt,
    input  logic                                 m_rvalid,
    input  logic [3:0]                           m_rdata,
    input  logic                                 m_fault
);

    localparam int OFS   = $clog2(LINE_LENGTH);
    localparam int NIB   = line_nibbles(LINE_LENGTH);
    localparam int DN    = RV / 4;
    localparam int BUF_N = (NIB > DN) ? NIB : DN;
    localparam int KW    = nib_w(BUF_N);

    state_e                   state, state_nx;
    owner_e                   owner;
    logic [KW-1:0]            k;
    logic [PA-1:0]            addr_q;
    logic [M_CNT_W-1:0]       cnt_q;
    logic [BUF_N-1:0][3:0]    line_buf;
    logic                     go, pick, coll_last, burst_last, busy;

    assign go         = (state == IDLE) && (i_pull || d_req);
    assign coll_last  = (M_CNT_W'(k) == cnt_q - M_CNT_W'(1));
    assign burst_last = (k == KW'(NIB - 1));
    assign busy       = (state == REQ) || (state == COLLECT);

    fill_rr_pick u_pick (
`ifdef FILL_RR_EN
        .clk   (clk),
        .reset (reset),
        .take  (go),
`endif
        .i_req (i_pull),
        .d_req (d_req),
        .pick  (pick)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = REQ;
            REQ:     if (m_fault) state_nx = IDLE;
                     else if (m_gnt) state_nx = COLLECT;
            COLLECT: if (m_fault) state_nx = IDLE;
                     else if (m_rvalid && coll_last)
                         state_nx = (owner == OWN_I) ? IBURST : DRESP;
            IBURST:  if (burst_last) state_nx = HOLD;
            DRESP:   state_nx = IDLE;
            HOLD:    state_nx = IDLE;  // swallow the stale miss still on i_pull
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            owner  <= OWN_I;
            k      <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (go) begin
                    owner  <= pick ? OWN_D : OWN_I;
                    addr_q <= pick ? d_addr : {i_tag, {OFS{1'b0}}};
                    cnt_q  <= pick ? M_CNT_W'(DN) : M_CNT_W'(NIB);
                    k      <= '0;
                end
                COLLECT: if (m_fault)
                    k <= '0;
                else if (m_rvalid)
                    k <= coll_last ? '0 : k + KW'(1);
                IBURST: k <= burst_last ? '0 : k + KW'(1);
                default: ;
            endcase
        end
    end

    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state == COLLECT && m_rvalid && !m_fault)
            line_buf[k] <= m_rdata;
    end

    assign m_req     = (state == REQ);
    assign m_addr    = addr_q;
    assign m_cnt     = cnt_q;
    assign i_wstrobe = (state == IBURST);
    assign i_dread   = i_wstrobe ? line_buf[k] : 4'h0;
    assign d_ack     = (state == DRESP);
    assign d_rdata   = d_ack ? line_buf[DN-1:0] : '0;
    assign i_fault   = busy && m_fault && (owner == OWN_I);
    assign d_fault   = busy && m_fault && (owner == OWN_D);

endmodule

// File: tb/tb_fill_arb.sv
// Directed bench for fill_arb with a transaction-level expectation model and a
// per-cycle compare process.
module tb_fill_arb;
    import fill_pkg::*;

    localparam int PA  = 22;
    localparam int TW  = 20;
    localparam int RV  = 16;
    localparam int NIB = LINE_NIBBLES;
`ifdef FILL_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk, reset, i_pull, d_req, m_gnt, m_rvalid, m_fault;
    logic [TW-1:0] i_tag;
    logic [PA-1:0] d_addr, m_addr;
    logic [3:0]    m_rdata, i_dread;
    logic          i_wstrobe, i_fault, d_ack, d_fault, m_req;
    logic [RV-1:0] d_rdata;
    logic [4:0]    m_cnt;

    fill_arb #(.LINE_LENGTH(4), .PA(PA), .RV(RV)) dut (
        .clk(clk), .reset(reset), .i_pull(i_pull), .i_tag(i_tag),
        .i_wstrobe(i_wstrobe), .i_dread(i_dread), .i_fault(i_fault),
        .d_req(d_req), .d_addr(d_addr), .d_ack(d_ack), .d_fault(d_fault),
        .d_rdata(d_rdata), .m_req(m_req), .m_addr(m_addr), .m_cnt(m_cnt),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_fault(m_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int n_strobe = 0, n_dack = 0, n_ifault = 0, n_dfault = 0;

    // Model state: who owns the transaction, what memory must see, nibbles returned.
    bit            model_ptr;      // 0 = icache favoured on a tie
    bit            exp_owner;      // 0 = icache, 1 = data
    logic [PA-1:0] exp_addr;
    int            exp_cnt;
    bit            mreq_allowed, collecting;
    logic [3:0]    fill_q[$];
    int            burst_left;
    bit            ack_due;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic [RV-1:0] pack_exp();
        logic [RV-1:0] v = '0;
        for (int i = 0; i < RV/4; i++) v[i*4 +: 4] = fill_q[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            burst_left = 0;
            ack_due    = 1'b0;
            collecting = 1'b0;
        end else begin
            chk("i_wstrobe", {31'b0, i_wstrobe}, {31'b0, burst_left > 0});
            if (burst_left > 0 && i_wstrobe && fill_q.size() == NIB)
                chk("i_dread", {28'b0, i_dread}, {28'b0, fill_q[NIB - burst_left]});
            chk("d_ack", {31'b0, d_ack}, {31'b0, ack_due});
            if (ack_due && d_ack && fill_q.size() == RV/4)
                chk("d_rdata", {16'b0, d_rdata}, {16'b0, pack_exp()});
            chk("i_fault", {31'b0, i_fault}, {31'b0, m_fault && !exp_owner});
            chk("d_fault", {31'b0, d_fault}, {31'b0, m_fault && exp_owner});
            chk("m_req_spurious", {31'b0, m_req && !mreq_allowed}, 32'd0);
            if (m_req) begin
                chk("m_addr", {10'b0, m_addr}, {10'b0, exp_addr});
                chk("m_cnt", {27'b0, m_cnt}, exp_cnt);
            end
            n_strobe += int'(i_wstrobe);
            n_dack   += int'(d_ack);
            n_ifault += int'(i_fault);
            n_dfault += int'(d_fault);
            if (burst_left > 0) burst_left--;
            ack_due = 1'b0;
            if (collecting && m_rvalid && !m_fault && fill_q.size() == exp_cnt) begin
                collecting = 1'b0;
                if (!exp_owner) burst_left = NIB;
                else            ack_due = 1'b1;
            end
        end
    end

    // Arbitration model: ties go to the favoured side, lone requests win outright.
    task automatic begin_serve();
        bit w;
        if (i_pull && d_req) w = RR ? model_ptr : 1'b0;
        else                 w = !i_pull;
        model_ptr    = !w;
        exp_owner    = w;
        exp_addr     = w ? d_addr : {i_tag, 2'b00};
        exp_cnt      = w ? RV/4 : NIB;
        mreq_allowed = 1'b1;
    endtask

    task automatic mem_respond(input int base, input int gaps, input int fault_after);
        int t = 0;
        while (!m_req && t < 20) begin step(); t++; end
        chk("m_req_seen", {31'b0, m_req}, 32'd1);
        if (!m_req) return;
        repeat (2) begin step(); chk("m_req_held", {31'b0, m_req}, 32'd1); end
        m_gnt = 1'b1;
        step();
        m_gnt = 1'b0;
        mreq_allowed = 1'b0;
        fill_q.delete();
        collecting = 1'b1;
        chk("m_req_after_gnt", {31'b0, m_req}, 32'd0);
        for (int i = 0; i < exp_cnt; i++) begin
            if (i == fault_after) begin
                m_fault = 1'b1;
                step();
                m_fault = 1'b0;
                collecting = 1'b0;
                return;
            end
            if (gaps[i]) step();
            m_rvalid = 1'b1;
            m_rdata  = 4'((base + i) & 15);
            fill_q.push_back(m_rdata);
            step();
            m_rvalid = 1'b0;
        end
    endtask

    // Returns in the first cycle after the strobe burst (the HOLD cycle).
    task automatic wait_burst_end();
        int t = 0;
        while (!i_wstrobe && t < 40) begin step(); t++; end
        while (i_wstrobe && t < 40) begin step(); t++; end
        chk("burst_timeout", {31'b0, t >= 40}, 32'd0);
    endtask

    task automatic complete();
        int t = 0;
        if (!exp_owner) begin
            wait_burst_end();
            i_pull = 1'b0;
        end else begin
            while (!d_ack && t < 20) begin step(); t++; end
            chk("d_ack_seen", {31'b0, d_ack}, 32'd1);
            step();
            d_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0, f0, g0;
        reset = 1'b1; i_pull = 1'b0; d_req = 1'b0; i_tag = '0; d_addr = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_fault = 1'b0;
        model_ptr = 1'b0; exp_owner = 1'b0; exp_addr = '0; exp_cnt = 0;
        mreq_allowed = 1'b0; collecting = 1'b0; burst_left = 0; ack_due = 1'b0;
        repeat (3) step();
        chk("rst_m_req", {31'b0, m_req}, 32'd0);
        chk("rst_m_addr", {10'b0, m_addr}, 32'd0);
        chk("rst_i_wstrobe", {31'b0, i_wstrobe}, 32'd0);
        chk("rst_i_dread", {28'b0, i_dread}, 32'd0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'd0);
        chk("rst_d_rdata", {16'b0, d_rdata}, 32'd0);
        reset = 1'b0;
        step();

        // icache fill with gaps; i_pull stays up into HOLD
        i_tag = 20'h12345; i_pull = 1'b1;
        begin_serve();
        chk("t1_model_addr", {10'b0, exp_addr}, 32'h48D14);
        step();
        chk("t1_m_req", {31'b0, m_req}, 32'd1);
        chk("t1_m_addr", {10'b0, m_addr}, 32'h48D14);
        chk("t1_m_cnt", {27'b0, m_cnt}, 32'd8);
        s0 = n_strobe;
        mem_respond(0, 'b10101010, -1);
        wait_burst_end();
        chk("t1_strobes", n_strobe - s0, 32'd8);
        chk("t1_hold_m_req", {31'b0, m_req}, 32'd0);
        i_pull = 1'b0;
        step();
        chk("t1_idle_m_req", {31'b0, m_req}, 32'd0);
        repeat (3) step();

        // data read: nibbles A,B,C,D
        d_addr = 22'h0100; d_req = 1'b1;
        begin_serve();
        step();
        chk("t2_m_addr", {10'b0, m_addr}, 32'h100);
        chk("t2_m_cnt", {27'b0, m_cnt}, 32'd4);
        a0 = n_dack;
        mem_respond(10, 'b0110, -1);
        chk("t2_d_ack", {31'b0, d_ack}, 32'd1);
        chk("t2_d_rdata", {16'b0, d_rdata}, 32'hDCBA);
        step();
        d_req = 1'b0;
        chk("t2_ack_count", n_dack - a0, 32'd1);
        repeat (2) step();

        // two ties in a row: icache first, then per arbitration mode
        i_tag = 20'h00ABC; d_addr = 22'h0200; i_pull = 1'b1; d_req = 1'b1;
        begin_serve();
        chk("t3_first_owner", {31'b0, exp_owner}, 32'd0);
        mem_respond(3, 'b00010000, -1);
        wait_burst_end();
        chk("t3_hold_m_req", {31'b0, m_req}, 32'd0);
        i_tag = 20'h00DEF;
        begin_serve();
        chk("t3_second_owner", {31'b0, exp_owner}, {31'b0, RR});
        mem_respond(5, 0, -1);
        complete();
        begin_serve();
        mem_respond(9, 'b0001, -1);
        complete();
        repeat (2) step();

        // icache fault after 3 nibbles, then immediate data request
        i_tag = 20'h00F00; i_pull = 1'b1;
        begin_serve();
        f0 = n_ifault; s0 = n_strobe;
        mem_respond(0, 0, 3);
        i_pull = 1'b0; d_addr = 22'h0300; d_req = 1'b1;
        begin_serve();
        step();
        chk("t4_idle_next", {31'b0, m_req}, 32'd1);
        chk("t4_ifault_count", n_ifault - f0, 32'd1);
        chk("t4_no_strobe", n_strobe - s0, 32'd0);
        mem_respond(1, 0, -1);
        complete();
        repeat (2) step();

        // data fault
        d_addr = 22'h0400; d_req = 1'b1;
        begin_serve();
        g0 = n_dfault; a0 = n_dack;
        mem_respond(6, 0, 2);
        d_req = 1'b0;
        chk("t5_dfault_count", n_dfault - g0, 32'd1);
        chk("t5_no_ack", n_dack - a0, 32'd0);
        repeat (2) step();

        // reset during the fourth strobe cycle, then refill from scratch
        i_tag = 20'h0A5A5; i_pull = 1'b1;
        begin_serve();
        mem_respond(8, 0, -1);
        repeat (3) step();
        chk("t6_mid_burst", {31'b0, i_wstrobe}, 32'd1);
        a0 = n_dack; f0 = n_ifault; g0 = n_dfault;
        reset = 1'b1;
        step();
        chk("t6_rst_strobe", {31'b0, i_wstrobe}, 32'd0);
        chk("t6_rst_dread", {28'b0, i_dread}, 32'd0);
        chk("t6_rst_m_req", {31'b0, m_req}, 32'd0);
        chk("t6_rst_m_addr", {10'b0, m_addr}, 32'd0);
        reset = 1'b0;
        model_ptr = 1'b0;
        begin_serve();
        s0 = n_strobe;
        mem_respond(4, 'b00000100, -1);
        wait_burst_end();
        i_pull = 1'b0;
        chk("t6_refill_strobes", n_strobe - s0, 32'd8);
        chk("t6_no_pulses", (n_dack - a0) + (n_ifault - f0) + (n_dfault - g0), 32'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fill_arb.md
FILL_ARB -- requirements
Module: fill_arb

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 4, icache line length in bytes (line = LINE_LENGTH*2 nibbles).
REQ-002 SHALL have parameter PA, default 22, physical address width.
REQ-003 SHALL have parameter RV, default 16, data-port word width (RV/4 nibbles).
REQ-004 SHALL have clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have i_pull  in  1  icache miss / line-fill request.
REQ-007 SHALL have i_tag  in  PA-log2(LINE_LENGTH)  line address of the miss.
REQ-008 SHALL have i_wstrobe  out  1  nibble write strobe to icache.
REQ-009 SHALL have i_dread  out  4  nibble to icache.
REQ-010 SHALL have i_fault  out  1  one-cycle pulse: line fill aborted.
REQ-011 SHALL have d_req, d_addr  in  1, PA  data read request, held until d_ack or d_fault.
REQ-012 SHALL have d_ack, d_fault  out  1, 1  one-cycle completion or abort pulse.
REQ-013 SHALL have d_rdata  out  RV  read data, valid in the d_ack cycle.
REQ-014 SHALL have m_req, m_addr, m_cnt  out  1, PA, 5  memory request, start address, nibble count.
REQ-015 SHALL have m_gnt  in  1  memory accepts request this cycle.
REQ-016 SHALL have m_rvalid, m_rdata, m_fault  in  1, 4, 1  returned nibble, with gaps allowed; abort.

Function
REQ-017 SHALL implement states IDLE, REQ, COLLECT, IBURST, DRESP, HOLD.
REQ-018 In IDLE, with i_pull or d_req asserted, SHALL latch the winner, drive m_req/m_addr/m_cnt, and enter REQ.
REQ-019 For an icache winner, SHALL drive m_addr={i_tag, log2(LINE_LENGTH) zeros} and m_cnt=LINE_LENGTH*2; for a data winner, SHALL drive m_addr=d_addr and m_cnt=RV/4.
REQ-020 SHALL hold m_req and its address/count stable in REQ until m_gnt, then enter COLLECT with m_req low.
REQ-021 In COLLECT, SHALL store each m_rvalid nibble into the line buffer at index k (k from 0, low nibble of lowest byte first) and increment k.
REQ-022 When the last nibble is stored, SHALL enter IBURST for icache or DRESP for data.
REQ-023 In IBURST, SHALL assert i_wstrobe for exactly LINE_LENGTH*2 consecutive cycles with i_dread=buffer[0..N-1] in order; no gap is permitted, because the icache nibble counter clears whenever the strobe drops.
REQ-024 After IBURST, SHALL spend one cycle in HOLD, ignoring i_pull, so the stale miss is not refilled.
REQ-025 In DRESP, SHALL pulse d_ack for one cycle with d_rdata=buffer[RV/4-1:0] (nibble 0 in bits 3:0), then return to IDLE.
REQ-026 On m_fault in REQ or COLLECT, SHALL abort with no icache strobes, pulse i_fault or d_fault for the owner, and return to IDLE next cycle.
REQ-027 Arbitration is fixed priority, icache over data, when both requests are active in IDLE.
REQ-028 Requests arriving outside IDLE SHALL wait, with no loss while the request is held.

Reset
REQ-029 Reset SHALL force IDLE, k=0, and the round-robin pointer to icache.
REQ-030 Reset SHALL drive all strobes, pulses and m_req to 0, and d_rdata, i_dread and m_addr to 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no ack or fault pulse; buffer contents are don't-care.

Configuration
REQ-032 With FILL_RR_EN defined, arbitration SHALL be round-robin: on a tie, the winner is the requester not granted last, and the pointer updates on every grant.
REQ-033 Without FILL_RR_EN, REQ-027 fixed priority SHALL apply and no pointer register SHALL exist.

Structure
REQ-034 The state enum, nibble-count widths and the LINE_NIBBLES=LINE_LENGTH*2 constant SHALL live in a shared package fill_pkg.
REQ-035 The arbiter SHALL be a sub-module fill_rr_pick (2-way pick, last-grant pointer), with its pointer compiled out when FILL_RR_EN is absent.

Verification
REQ-036 i_pull, i_tag=0x12345, m_gnt after 2 cycles, nibbles 0..7 with gaps -> m_addr=0x48D14, m_cnt=8, then i_wstrobe high 8 consecutive cycles with i_dread 0..7, then HOLD.
REQ-037 d_req, d_addr=0x0100, nibbles A,B,C,D -> m_cnt=4, single d_ack with d_rdata=0xDCBA.
REQ-038 i_pull and d_req asserted in the same cycle -> icache served first; with FILL_RR_EN, a second tie serves data.
REQ-039 m_fault after 3 of 8 fill nibbles -> no i_wstrobe, i_fault pulses once, IDLE next cycle.
REQ-040 reset asserted mid-IBURST (cycle 4) -> i_wstrobe=0 next cycle, IDLE, no pulses; a new i_pull then refills from scratch.
REQ-041 i_pull still high in the HOLD cycle -> no new m_req that cycle.
